rgb2yuv: RTL and testbench

RGB2YUV -- requirements
Module: rgb2yuv

---
 rtl/jisp_pkg.sv | 18 +
 rtl/csc_dot3.sv | 45 ++++
 rtl/rgb2yuv.sv | 82 ++++++++
 tb/tb_rgb2yuv.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jisp_pkg.sv
// Shared constants for the JFIF BT.601 full-range RGB -> YCbCr converter.
package jisp_pkg;

  localparam int CSC_CW    = 10;
  localparam int CSC_RND   = 128;
  localparam int CSC_OFS   = 128;
  localparam int CSC_SHIFT = 8;

  typedef logic signed [CSC_CW-1:0] coef_t;

  // Rows: Y, Cb, Cr. Columns: R, G, B.
  localparam coef_t CSC_COEF [3][3] = '{
    '{coef_t'(77),  coef_t'(150),  coef_t'(29)},
    '{coef_t'(-43), coef_t'(-85),  coef_t'(128)},
    '{coef_t'(128), coef_t'(-107), coef_t'(-21)}
  };

endpackage

// File: rtl/csc_dot3.sv
// One output row of the colour matrix: products registered, then rounded sum registered.
// Two cycles of latency; both stages freeze while i_en is low.
module csc_dot3
  import jisp_pkg::*;
#(
  parameter int DW  = 8,
  parameter int CW  = CSC_CW,
  parameter int ROW = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_en,
  input  logic [DW-1:0]          i_px [3],
  output logic signed [CW+DW+2:0] o_sum
);

  localparam int PW = CW + DW + 1;
  localparam int SW = CW + DW + 3;

  logic signed [PW-1:0] w_coef [3];
  logic signed [PW-1:0] w_px   [3];
  logic signed [PW-1:0] r_prod [3];
  logic signed [SW-1:0] r_sum;

  // Pixels enter as unsigned; a zero MSB makes them non-negative signed operands.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_coef[k] = PW'(CSC_COEF[ROW][k]);
      w_px[k]   = PW'(signed'({1'b0, i_px[k]}));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 3; k++) r_prod[k] <= '0;
      r_sum <= '0;
    end else if (i_en) begin
      for (int k = 0; k < 3; k++) r_prod[k] <= w_coef[k] * w_px[k];
      r_sum <= SW'(r_prod[0]) + SW'(r_prod[1]) + SW'(r_prod[2]) + SW'(CSC_RND);
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/rgb2yuv.sv
// RGB -> YCbCr 3-stage pipeline, result 3 cycles after acceptance at 1 pixel/clk.
// yuv_out_hold freezes every stage and is passed straight back as rgb_in_hold.
module rgb2yuv
  import jisp_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = CSC_CW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] rgb_in [3],
  input  logic          rgb_in_valid,
  output logic          rgb_in_hold,
  input  logic          frame_valid_in,
  input  logic          line_valid_in,
  output logic [DW-1:0] yuv_out [3],
  output logic          yuv_out_valid,
  input  logic          yuv_out_hold,
  output logic          frame_valid_out,
  output logic          line_valid_out
);

  localparam int SW   = CW + DW + 3;
  localparam int MAXV = (1 << DW) - 1;

  logic                 w_en;
  logic                 w_acc;
  logic signed [SW-1:0] w_sum   [3];
  logic signed [SW-1:0] w_shf   [3];
  logic [DW-1:0]        w_clamp [3];
  logic [2:0]           r_vld;
  logic [2:0]           r_fv;
  logic [2:0]           r_lv;
  logic [DW-1:0]        r_yuv   [3];

  assign w_en        = ~yuv_out_hold;
  assign rgb_in_hold = yuv_out_hold;
  assign w_acc       = rgb_in_valid & ~rgb_in_hold;

  for (genvar c = 0; c < 3; c++) begin : g_row
    csc_dot3 #(.DW(DW), .CW(CW), .ROW(c)) u_dot (
      .clk    (clk),
      .resetn (resetn),
      .i_en   (w_en),
      .i_px   (rgb_in),
      .o_sum  (w_sum[c])
    );
  end

  // Floor shift, chroma offset, then saturate into the output range.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      w_shf[c] = (w_sum[c] >>> CSC_SHIFT) + ((c == 0) ? SW'(0) : SW'(CSC_OFS));
      if (w_shf[c] < 0)
        w_clamp[c] = '0;
      else if (w_shf[c] > SW'(MAXV))
        w_clamp[c] = '1;
      else
        w_clamp[c] = w_shf[c][DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld <= '0;
      r_fv  <= '0;
      r_lv  <= '0;
      for (int c = 0; c < 3; c++) r_yuv[c] <= '0;
    end else if (w_en) begin
      r_vld <= {r_vld[1:0], w_acc};
      r_fv  <= {r_fv[1:0], frame_valid_in};
      r_lv  <= {r_lv[1:0], line_valid_in};
      for (int c = 0; c < 3; c++) r_yuv[c] <= w_clamp[c];
    end
  end

  assign yuv_out         = r_yuv;
  assign yuv_out_valid   = r_vld[2];
  assign frame_valid_out = r_fv[2];
  assign line_valid_out  = r_lv[2];

endmodule

// File: tb/tb_rgb2yuv.sv
// Bench for rgb2yuv: fixed colour vectors, randomized streams with holds, envelope and reset scenarios.
module tb_rgb2yuv;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] rgb_in [3];
  logic       rgb_in_valid;
  logic       rgb_in_hold;
  logic       frame_valid_in;
  logic       line_valid_in;
  logic [7:0] yuv_out [3];
  logic       yuv_out_valid;
  logic       yuv_out_hold;
  logic       frame_valid_out;
  logic       line_valid_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rgb2yuv #(.DW(8), .CW(10)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .rgb_in          (rgb_in),
    .rgb_in_valid    (rgb_in_valid),
    .rgb_in_hold     (rgb_in_hold),
    .frame_valid_in  (frame_valid_in),
    .line_valid_in   (line_valid_in),
    .yuv_out         (yuv_out),
    .yuv_out_valid   (yuv_out_valid),
    .yuv_out_hold    (yuv_out_hold),
    .frame_valid_out (frame_valid_out),
    .line_valid_out  (line_valid_out)
  );

  // Reference: pixels in flight with the number of unheld edges they have seen.
  typedef struct {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    int         age;
  } exp_t;

  exp_t pq [$];
  logic env_fv [$];
  logic env_lv [$];

  function automatic int floor256(int a);
    return (a >= 0) ? a / 256 : -((-a + 255) / 256);
  endfunction

  function automatic logic [7:0] sat8(int v);
    return (v < 0) ? 8'd0 : (v > 255) ? 8'd255 : 8'(v);
  endfunction

  function automatic exp_t ref_px(int r, int g, int b);
    exp_t e;
    e.y   = sat8(floor256(77 * r + 150 * g + 29 * b + 128));
    e.cb  = sat8(floor256(-43 * r - 85 * g + 128 * b + 128) + 128);
    e.cr  = sat8(floor256(128 * r - 107 * g - 21 * b + 128) + 128);
    e.age = 0;
    return e;
  endfunction

  function automatic logic exp_valid();
    return (pq.size() > 0) && (pq[0].age >= 3);
  endfunction

  task automatic model_reset();
    pq.delete();
    env_fv.delete();
    env_lv.delete();
    for (int i = 0; i < 3; i++) begin
      env_fv.push_back(1'b0);
      env_lv.push_back(1'b0);
    end
  endtask

  task automatic model_edge();
    exp_t e;
    if (resetn && !yuv_out_hold) begin
      if (exp_valid()) void'(pq.pop_front());
      foreach (pq[i]) pq[i].age = pq[i].age + 1;
      if (rgb_in_valid) begin
        e = ref_px(rgb_in[0], rgb_in[1], rgb_in[2]);
        e.age = 1;
        pq.push_back(e);
      end
      env_fv.push_back(frame_valid_in);
      env_lv.push_back(line_valid_in);
      void'(env_fv.pop_front());
      void'(env_lv.pop_front());
    end
  endtask

  // Called at a negedge; applies inputs for the coming posedge and returns at the next negedge.
  task automatic drive(input logic vld, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic fv, input logic lv, input logic hold);
    rgb_in_valid   = vld;
    rgb_in[0]      = r;
    rgb_in[1]      = g;
    rgb_in[2]      = b;
    frame_valid_in = fv;
    line_valid_in  = lv;
    yuv_out_hold   = hold;
    #1;
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rgb_in_valid = 1'b0;
    yuv_out_hold = 1'b0;
    frame_valid_in = 1'b0;
    line_valid_in  = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    resetn         = 1'b0;
    rgb_in_valid   = 1'b1;
    frame_valid_in = 1'b1;
    line_valid_in  = 1'b1;
    yuv_out_hold   = 1'b0;
    for (int c = 0; c < 3; c++) rgb_in[c] = 8'd200;
    repeat (3) @(negedge clk);
    n_vec++;
    if (yuv_out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_vld: got %b want 0", yuv_out_valid);
    end
    n_vec++;
    if ({yuv_out[0], yuv_out[1], yuv_out[2]} !== 24'h0) begin
      n_err++; $display("FAIL reset_yuv: got %h want 000000", {yuv_out[0], yuv_out[1], yuv_out[2]});
    end
    n_vec++;
    if ({frame_valid_out, line_valid_out} !== 2'b00) begin
      n_err++; $display("FAIL reset_env: got %b%b want 00", frame_valid_out, line_valid_out);
    end
    for (int h = 0; h < 2; h++) begin
      yuv_out_hold = (h == 0);
      #1;
      n_vec++;
      if (rgb_in_hold !== yuv_out_hold) begin
        n_err++; $display("FAIL reset_hold_passthru: got %b want %b", rgb_in_hold, yuv_out_hold);
      end
    end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_colors();
    logic [7:0] tin  [5][3];
    logic [7:0] tout [5][3];
    tin  = '{'{255, 255, 255}, '{0, 0, 0}, '{255, 0, 0}, '{0, 255, 0}, '{0, 0, 255}};
    tout = '{'{255, 128, 128}, '{0, 128, 128}, '{77, 85, 255}, '{149, 43, 21}, '{29, 255, 107}};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, tin[i][0], tin[i][1], tin[i][2], 1'b1, 1'b1, 1'b0);
      for (int j = 1; j <= 3; j++) begin
        n_vec++;
        if (yuv_out_valid !== (j == 3)) begin
          n_err++; $display("FAIL color%0d_vld_t%0d: got %b want %b", i, j, yuv_out_valid, (j == 3));
        end
        if (j < 3) drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
      end
      n_vec++;
      if ({yuv_out[0], yuv_out[1], yuv_out[2]} !== {tout[i][0], tout[i][1], tout[i][2]}) begin
        n_err++;
        $display("FAIL color%0d_data: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                 yuv_out[0], yuv_out[1], yuv_out[2], tout[i][0], tout[i][1], tout[i][2]);
      end
    end
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_random_stream();
    logic       lv;
    logic       hold;
    logic       prev_hold;
    logic [7:0] prev_yuv [3];
    lv = 1'b1;
    prev_hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i % 37 == 36) lv = ~lv;
      hold = ($urandom_range(0, 4) == 0);
      prev_yuv = yuv_out;
      drive(lv && ($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom), 8'($urandom),
            1'b1, lv, hold);
      prev_hold = hold;
      n_vec++;
      if (rgb_in_hold !== yuv_out_hold) begin
        n_err++; $display("FAIL rand_hold_passthru cyc %0d: got %b want %b", i, rgb_in_hold, yuv_out_hold);
      end
      n_vec++;
      if (yuv_out_valid !== exp_valid()) begin
        n_err++; $display("FAIL rand_vld cyc %0d: got %b want %b", i, yuv_out_valid, exp_valid());
      end
      if (exp_valid() && yuv_out_valid) begin
        n_vec++;
        if ({yuv_out[0], yuv_out[1], yuv_out[2]} !== {pq[0].y, pq[0].cb, pq[0].cr}) begin
          n_err++;
          $display("FAIL rand_data cyc %0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                   yuv_out[0], yuv_out[1], yuv_out[2], pq[0].y, pq[0].cb, pq[0].cr);
        end
      end
      if (prev_hold) begin
        n_vec++;
        if (yuv_out !== prev_yuv) begin
          n_err++; $display("FAIL rand_hold_stable cyc %0d: yuv_out changed while held", i);
        end
      end
      n_vec++;
      if ({frame_valid_out, line_valid_out} !== {env_fv[0], env_lv[0]}) begin
        n_err++;
        $display("FAIL rand_env cyc %0d: got %b%b want %b%b", i, frame_valid_out, line_valid_out,
                 env_fv[0], env_lv[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t       seq [16];
    logic [7:0] pix [16][3];
    int         sent;
    int         got;
    int         cyc;
    logic       hold;
    logic       v;
    logic [7:0] snap [3];
    do_reset();
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 3; c++) pix[i][c] = 8'($urandom);
      seq[i] = ref_px(pix[i][0], pix[i][1], pix[i][2]);
    end
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (cyc < 40) begin
      v    = yuv_out_valid;
      snap = yuv_out;
      hold = (cyc >= 6 && cyc < 11);
      if (v && !hold) begin
        if (got < 16) begin
          n_vec++;
          if ({snap[0], snap[1], snap[2]} !== {seq[got].y, seq[got].cb, seq[got].cr}) begin
            n_err++;
            $display("FAIL b2b_order px %0d: got %0d/%0d/%0d want %0d/%0d/%0d", got,
                     snap[0], snap[1], snap[2], seq[got].y, seq[got].cb, seq[got].cr);
          end
        end
        got++;
      end
      if (sent < 16)
        drive(1'b1, pix[sent][0], pix[sent][1], pix[sent][2], 1'b1, 1'b1, hold);
      else
        drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, hold);
      if (!hold && sent < 16) sent++;
      n_vec++;
      if (rgb_in_hold !== hold) begin
        n_err++; $display("FAIL b2b_hold_passthru cyc %0d: got %b want %b", cyc, rgb_in_hold, hold);
      end
      if (hold) begin
        n_vec++;
        if (yuv_out_valid !== v || yuv_out !== snap) begin
          n_err++; $display("FAIL b2b_hold_stable cyc %0d: output moved under hold", cyc);
        end
      end
      n_vec++;
      if (yuv_out_valid !== exp_valid()) begin
        n_err++; $display("FAIL b2b_vld cyc %0d: got %b want %b", cyc, yuv_out_valid, exp_valid());
      end
      cyc++;
    end
    n_vec++;
    if (got !== 16) begin
      n_err++; $display("FAIL b2b_count: got %0d pixels want 16", got);
    end
  endtask

  task automatic test_line_hold();
    int   falls;
    int   got;
    int   unheld_since;
    logic prev_lv;
    logic hold;
    do_reset();
    falls = 0;
    got = 0;
    unheld_since = -1;
    prev_lv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      hold = (i >= 6 && i < 9);
      if (yuv_out_valid && !hold) got++;
      if (i < 6)
        drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1, hold);
      else
        drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, hold);
      if (i >= 6 && !hold) unheld_since = (unheld_since < 0) ? 1 : unheld_since + 1;
      n_vec++;
      if (line_valid_out !== env_lv[0]) begin
        n_err++; $display("FAIL line_env cyc %0d: got %b want %b", i, line_valid_out, env_lv[0]);
      end
      if (prev_lv && !line_valid_out) begin
        falls++;
        n_vec++;
        if (unheld_since !== 3) begin
          n_err++; $display("FAIL line_fall_delay: got %0d unheld edges want 3", unheld_since);
        end
        n_vec++;
        if (got !== 6) begin
          n_err++; $display("FAIL line_fall_order: got %0d pixels out before fall want 6", got);
        end
      end
      prev_lv = line_valid_out;
    end
    n_vec++;
    if (falls !== 1) begin
      n_err++; $display("FAIL line_fall_count: got %0d want 1", falls);
    end
  endtask

  task automatic test_reset_midline();
    do_reset();
    for (int i = 0; i < 3; i++)
      drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b0);
    #2 resetn = 1'b0;
    #1;
    n_vec++;
    if ({yuv_out_valid, frame_valid_out, line_valid_out} !== 3'b000) begin
      n_err++;
      $display("FAIL midreset_flags: got %b%b%b want 000", yuv_out_valid, frame_valid_out, line_valid_out);
    end
    n_vec++;
    if ({yuv_out[0], yuv_out[1], yuv_out[2]} !== 24'h0) begin
      n_err++; $display("FAIL midreset_yuv: got %h want 000000", {yuv_out[0], yuv_out[1], yuv_out[2]});
    end
    rgb_in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
      n_vec++;
      if (yuv_out_valid !== 1'b0) begin
        n_err++; $display("FAIL midreset_stale cyc %0d: got %b want 0", i, yuv_out_valid);
      end
    end
    drive(1'b1, 8'd255, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (yuv_out_valid !== exp_valid()) begin
        n_err++; $display("FAIL midreset_new_vld t%0d: got %b want %b", i, yuv_out_valid, exp_valid());
      end
      drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rgb_in_valid   = 1'b0;
    yuv_out_hold   = 1'b0;
    frame_valid_in = 1'b0;
    line_valid_in  = 1'b0;
    for (int c = 0; c < 3; c++) rgb_in[c] = 8'd0;
    model_reset();
    test_reset();
    test_colors();
    test_random_stream();
    test_back_to_back();
    test_line_hold();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
